// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares the single rom port between m0 (instruction fetch, read-only) and
//   m1 (data/loader, read/write). m0 has fixed priority. m1 is forced through
//   after STARVE_MAX consecutive m0 grants while it waits. Each port allows one
//   outstanding request. A per-port hold buffer keeps the response stable while
//   the master back-pressures with rready low.
//
//   Optional feature macro: ROM_ARB_WP_EN (rom write protect). m1 writes are
//   still granted, but the rom never sees we/sel. The response carries
//   m1_err_o=1.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_req_i/addr_i               fetch request
//   m0_gnt_o                      request accepted this cycle (combinational)
//   m0_rvalid_o/rdata_o/rready_i  fetch response handshake
//   m1_req_i/addr_i/wdata_i/sel_i/we_i   data/loader request
//   m1_gnt_o/rvalid_o/rdata_o/err_o/rready_i  data response handshake
//   rom_addr_o/data_o/sel_o/we_o  rom request (byte address)
//   rom_data_i                    rom read data, one cycle after the address
module rom_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m0_rready_i,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  input  logic        m1_rready_i,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  output logic [3:0]  rom_sel_o,
  output logic        rom_we_o,
  input  logic [31:0] rom_data_i
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} st_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  st_e         st_q  [2];
  st_e         st_d  [2];
  logic [31:0] buf_q [2];
  logic [31:0] buf_d [2];
  logic [31:0] resp  [2];
  logic        wr_q, wr_d;        // m1's outstanding response belongs to a write
  logic [3:0]  starve_q, starve_d;

  logic [1:0]  req, rready, busy, elig, gnt;

  assign req    = {m1_req_i, m0_req_i};
  assign rready = {m1_rready_i, m0_rready_i};
  assign busy   = {st_q[1] != IDLE, st_q[0] != IDLE};

  // A port can take a new request when idle, or when its current response
  // is being accepted this very cycle.
  assign elig = req & (~busy | rready);

  assign gnt[0] = !rst && elig[0] && !(elig[1] && (starve_q == SMAX));
  assign gnt[1] = !rst && elig[1] && !gnt[0];

  // Write responses carry no data; the rom read port is ignored for them.
  assign resp[0] = rom_data_i;
  assign resp[1] = wr_q ? 32'h0 : rom_data_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      st_d[p]  = st_q[p];
      buf_d[p] = buf_q[p];
      unique case (st_q[p])
        IDLE: if (gnt[p]) st_d[p] = WAIT;
        WAIT: begin
          if (rready[p]) begin
            st_d[p] = gnt[p] ? WAIT : IDLE;
          end else begin
            // The rom data is only valid this cycle; freeze it for the master.
            st_d[p]  = HOLD;
            buf_d[p] = resp[p];
          end
        end
        HOLD: if (rready[p]) st_d[p] = gnt[p] ? WAIT : IDLE;
        default: st_d[p] = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_d = wr_q;
    if (gnt[1]) wr_d = m1_we_i;
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt[1] || !m1_req_i)                       starve_d = 4'd0;
    else if (gnt[0] && elig[1] && starve_q != SMAX) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= IDLE;
        buf_q[p] <= 32'h0;
      end
      wr_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= st_d[p];
        buf_q[p] <= buf_d[p];
      end
      wr_q     <= wr_d;
      starve_q <= starve_d;
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = busy[0] && !rst;
  assign m1_rvalid_o = busy[1] && !rst;
  assign m0_rdata_o  = rst ? 32'h0 : (st_q[0] == WAIT) ? resp[0] :
                       (st_q[0] == HOLD) ? buf_q[0] : 32'h0;
  assign m1_rdata_o  = rst ? 32'h0 : (st_q[1] == WAIT) ? resp[1] :
                       (st_q[1] == HOLD) ? buf_q[1] : 32'h0;

`ifdef ROM_ARB_WP_EN
  assign m1_err_o = m1_rvalid_o && wr_q;
`else
  assign m1_err_o = 1'b0;
`endif

  always_comb begin
    rom_addr_o = m0_addr_i;
    rom_data_o = 32'h0;
    rom_sel_o  = 4'h0;
    rom_we_o   = 1'b0;
    if (gnt[1]) begin
      rom_addr_o = m1_addr_i;
      rom_data_o = m1_wdata_i;
`ifdef ROM_ARB_WP_EN
      rom_sel_o  = m1_we_i ? 4'h0 : m1_sel_i;
`else
      rom_sel_o  = m1_sel_i;
      rom_we_o   = m1_we_i;
`endif
    end else if (gnt[0]) begin
      rom_sel_o = 4'hF;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a byte-enabled rom model with a 1-cycle read,
// directed vector table, hand sequences for writes and reset, then a random
// phase checked against a transaction-level reference model.
module tb_rom_arbiter;
  localparam int SM = 4;
`ifdef ROM_ARB_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_gnt_o, m0_rvalid_o, m0_rready_i;
  logic [31:0] m0_addr_i, m0_rdata_o;
  logic        m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o, m1_err_o, m1_rready_i;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_sel_i;
  logic [31:0] rom_addr_o, rom_data_o, rom_data_i;
  logic [3:0]  rom_sel_o;
  logic        rom_we_o;

  always #5 clk = ~clk;

  rom_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_rready_i(m0_rready_i),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .m1_rready_i(m1_rready_i),
    .rom_addr_o(rom_addr_o), .rom_data_o(rom_data_o), .rom_sel_o(rom_sel_o),
    .rom_we_o(rom_we_o), .rom_data_i(rom_data_i)
  );

  function automatic logic [31:0] init_w(int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b + 8'h40, b + 8'h80, b + 8'hC0};
  endfunction

  // rom: 64 words, preloaded on reset, read data registered
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_w(i);
    end else if (rom_we_o) begin
      for (int b = 0; b < 4; b++)
        if (rom_sel_o[b]) mem[rom_addr_o[7:2]][8*b +: 8] <= rom_data_o[8*b +: 8];
    end
    rom_data_i <= mem[rom_addr_o[7:2]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        y0;
    logic        r1;
    logic [31:0] a1;
    logic        g0, g1, v0, v1;
    logic [31:0] d0, d1;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t V(logic r0, logic [31:0] a0, logic y0, logic r1, logic [31:0] a1,
                             logic g0, logic g1, logic v0, logic [31:0] d0,
                             logic v1, logic [31:0] d1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.y0 = y0; v.r1 = r1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    return v;
  endfunction

  task automatic m1_xact(input logic we, input logic [31:0] a, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                         input bit stall, input string nm);
    m1_req_i = 1'b1; m1_we_i = we; m1_addr_i = a; m1_sel_i = sel; m1_wdata_i = wd;
    m1_rready_i = !stall;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(m1_gnt_o), 32'd1);
    chk({nm, "_rom_we_sel"}, 32'({rom_we_o, rom_sel_o}),
        32'({we && !WP, (we && WP) ? 4'h0 : sel}));
    @(posedge clk); #1;
    m1_req_i = 1'b0; m1_we_i = 1'b0;
    repeat (stall ? 2 : 1) begin
      @(negedge clk);
      chk({nm, "_rvalid"}, 32'(m1_rvalid_o), 32'd1);
      chk({nm, "_rdata"}, m1_rdata_o, ed);
      chk({nm, "_err"}, 32'(m1_err_o), 32'(ee));
      @(posedge clk); #1;
      m1_rready_i = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_done"}, 32'(m1_rvalid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // reference model state for the random phase
  bit          mb [2];
  logic [31:0] md [2];
  logic        me1;
  int          run;
  logic [31:0] gold [64];
  logic        el0, el1, eg0, eg1, sg0, sg1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_req_i = 0; m0_addr_i = 0; m0_rready_i = 1;
    m1_req_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_sel_i = 4'hF; m1_we_i = 0;
    m1_rready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    // reset state with both masters requesting
    m0_req_i = 1; m0_addr_i = 32'h8; m1_req_i = 1; m1_we_i = 1; m1_wdata_i = 32'h1234;
    @(negedge clk);
    chk("rst_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    chk("rst_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    chk("rst_err", 32'(m1_err_o), 32'd0);
    chk("rst_rom", 32'({rom_we_o, rom_sel_o}) | rom_data_o, 32'd0);
    chk("rst_rom_addr", rom_addr_o, 32'h8);
    @(posedge clk); #1;
    rst = 0; m0_req_i = 0; m1_req_i = 0; m1_we_i = 0; m1_wdata_i = 0;

    // burst, hold/back-pressure, starvation pattern
    tbl.push_back(V(1, 'h00, 1, 0, 'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 'h04, 1, 0, 'h0, 1, 0, 1, init_w(0), 0, 0));
    tbl.push_back(V(1, 'h08, 1, 0, 'h0, 1, 0, 1, init_w(1), 0, 0));
    tbl.push_back(V(0, 'h08, 1, 0, 'h0, 0, 0, 1, init_w(2), 0, 0));
    tbl.push_back(V(1, 'h10, 0, 0, 'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 'h20, 0, 0, 'h0, 0, 0, 1, init_w(4), 0, 0));
    tbl.push_back(V(1, 'h20, 0, 0, 'h0, 0, 0, 1, init_w(4), 0, 0));
    tbl.push_back(V(1, 'h20, 0, 0, 'h0, 0, 0, 1, init_w(4), 0, 0));
    tbl.push_back(V(1, 'h20, 1, 0, 'h0, 1, 0, 1, init_w(4), 0, 0));
    tbl.push_back(V(0, 'h20, 1, 0, 'h0, 0, 0, 1, init_w(8), 0, 0));
    tbl.push_back(V(0, 'h20, 1, 0, 'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 'h00, 1, 1, 'h4, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(V(1, 'h00, 1, 1, 'h4, 1, 0, 1, init_w(0), 0, 0));
    tbl.push_back(V(1, 'h00, 1, 1, 'h4, 0, 1, 1, init_w(0), 0, 0));
    tbl.push_back(V(1, 'h00, 1, 1, 'h4, 1, 0, 0, 0, 1, init_w(1)));
    for (int k = 0; k < 3; k++) tbl.push_back(V(1, 'h00, 1, 1, 'h4, 1, 0, 1, init_w(0), 0, 0));
    tbl.push_back(V(1, 'h00, 1, 1, 'h4, 0, 1, 1, init_w(0), 0, 0));
    tbl.push_back(V(0, 'h00, 1, 0, 'h4, 0, 0, 0, 0, 1, init_w(1)));
    tbl.push_back(V(0, 'h00, 1, 0, 'h4, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      m0_req_i = tbl[i].r0; m0_addr_i = tbl[i].a0; m0_rready_i = tbl[i].y0;
      m1_req_i = tbl[i].r1; m1_addr_i = tbl[i].a1; m1_rready_i = 1;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'({m1_gnt_o, m0_gnt_o}), 32'({tbl[i].g1, tbl[i].g0}));
      chk($sformatf("vec%0d_rvalid", i), 32'({m1_rvalid_o, m0_rvalid_o}),
          32'({tbl[i].v1, tbl[i].v0}));
      if (tbl[i].v0) chk($sformatf("vec%0d_rdata0", i), m0_rdata_o, tbl[i].d0);
      if (tbl[i].v1) chk($sformatf("vec%0d_rdata1", i), m1_rdata_o, tbl[i].d1);
      @(posedge clk); #1;
    end
    m0_req_i = 0; m1_req_i = 0;

    // m1 writes: full word (with a stalled response), then a single byte
    m1_xact(1, 32'h40, 4'hF, 32'hDEADBEEF, 32'h0, WP, 1, "wr40");
    m1_xact(0, 32'h40, 4'hF, 32'h0, WP ? init_w(16) : 32'hDEADBEEF, 0, 0, "rd40");
    m1_xact(1, 32'h44, 4'h1, 32'h000000AA, 32'h0, WP, 0, "wr44");
    m1_xact(0, 32'h44, 4'hF, 32'h0,
            WP ? init_w(17) : ((init_w(17) & 32'hFFFFFF00) | 32'hAA), 0, 0, "rd44");

    // reset while m0 sits in HOLD
    m0_req_i = 1; m0_addr_i = 32'h10; m0_rready_i = 0;
    @(negedge clk); chk("hr_gnt", 32'(m0_gnt_o), 32'd1);
    @(posedge clk); #1; m0_req_i = 0; m0_addr_i = 32'h20;
    @(negedge clk); chk("hr_wait", m0_rdata_o, init_w(4));
    @(posedge clk); #1;
    @(negedge clk); chk("hr_hold", m0_rdata_o, init_w(4));
    @(posedge clk); #1; rst = 1; m0_req_i = 1; m0_addr_i = 32'h8; m0_rready_i = 1;
    @(negedge clk); chk("hr_in_rst", 32'({m0_gnt_o, m0_rvalid_o}), 32'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("hr_dropped", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
    chk("hr_regnt", 32'(m0_gnt_o), 32'd1);
    @(posedge clk); #1; m0_req_i = 0;
    @(negedge clk); chk("hr_resp", m0_rdata_o, init_w(2));
    @(posedge clk); #1;

    // random phase against the reference model
    for (int i = 0; i < 64; i++) gold[i] = init_w(i);
    mb[0] = 0; mb[1] = 0; md[0] = 0; md[1] = 0; me1 = 0; run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req_i && $urandom_range(0, 3) != 0) begin
        m0_req_i = 1; m0_addr_i = 32'($urandom_range(0, 63)) << 2;
      end
      if (!m1_req_i && $urandom_range(0, 1) != 0) begin
        m1_req_i = 1; m1_addr_i = 32'($urandom_range(0, 63)) << 2;
        m1_we_i = ($urandom_range(0, 2) == 0); m1_sel_i = 4'($urandom_range(1, 15));
        m1_wdata_i = $urandom;
      end
      m0_rready_i = ($urandom_range(0, 3) != 0);
      m1_rready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      el0 = m0_req_i && (!mb[0] || m0_rready_i);
      el1 = m1_req_i && (!mb[1] || m1_rready_i);
      eg1 = el1 && (!el0 || run >= SM);
      eg0 = el0 && !eg1;
      chk("rnd_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'({eg1, eg0}));
      chk("rnd_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'({mb[1], mb[0]}));
      if (mb[0]) chk("rnd_rdata0", m0_rdata_o, md[0]);
      if (mb[1]) begin
        chk("rnd_rdata1", m1_rdata_o, md[1]);
        chk("rnd_err", 32'(m1_err_o), 32'(me1));
      end
      if (eg1) begin
        chk("rnd_rom_addr1", rom_addr_o, m1_addr_i);
        chk("rnd_rom_data1", rom_data_o, m1_wdata_i);
        chk("rnd_rom_ctl1", 32'({rom_we_o, rom_sel_o}),
            32'({m1_we_i && !WP, (WP && m1_we_i) ? 4'h0 : m1_sel_i}));
      end else begin
        chk("rnd_rom_addr0", rom_addr_o, m0_addr_i);
        chk("rnd_rom_ctl0", 32'({rom_we_o, rom_sel_o}), 32'({1'b0, eg0 ? 4'hF : 4'h0}));
      end
      sg0 = m0_gnt_o; sg1 = m1_gnt_o;
      // advance model across the coming edge
      if (eg1 || !m1_req_i) run = 0;
      else if (eg0 && el1 && run < SM) run++;
      if (eg0) begin
        mb[0] = 1; md[0] = gold[m0_addr_i[7:2]];
      end else if (mb[0] && m0_rready_i) mb[0] = 0;
      if (eg1) begin
        mb[1] = 1;
        if (m1_we_i) begin
          md[1] = 0; me1 = WP;
          if (!WP)
            for (int b = 0; b < 4; b++)
              if (m1_sel_i[b]) gold[m1_addr_i[7:2]][8*b +: 8] = m1_wdata_i[8*b +: 8];
        end else begin
          md[1] = gold[m1_addr_i[7:2]]; me1 = 0;
        end
      end else if (mb[1] && m1_rready_i) mb[1] = 0;
      @(posedge clk); #1;
      if (sg0) m0_req_i = 0;
      if (sg1) m1_req_i = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and response sequencer in front of the `rom` instruction memory. It shares the single ROM port between the core instruction-fetch master (m0) and the data/loader master (m1), which handles loads and program download. It uses fixed priority to m0, with a starvation bound for m1. Each port gets a one-outstanding request/response handshake with a response hold buffer, so masters may back-pressure.

## Interface
- `STARVE_MAX`, default 4: consecutive m0 grants allowed while m1 is pending before m1 is forced; range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req_i`  in  1  fetch request.
- `m0_addr_i`  in  32  fetch byte address.
- `m0_gnt_o`  out  1  request accepted this cycle (combinational).
- `m0_rvalid_o`  out  1  response valid.
- `m0_rdata_o`  out  32  fetched word.
- `m0_rready_i`  in  1  m0 accepts response.
- `m1_req_i`, `m1_addr_i`[31:0], `m1_wdata_i`[31:0], `m1_sel_i`[3:0], `m1_we_i`  in  data/loader request.
- `m1_gnt_o`, `m1_rvalid_o`, `m1_rdata_o`[31:0], `m1_rready_i`: same semantics as m0.
- `m1_err_o`  out  1  qualifies `m1_rvalid_o`; write rejected.
- `rom_addr_o`  out  32  byte address to `rom` (`rom` does the word conversion).
- `rom_data_o`  out  32  write data.
- `rom_sel_o`  out  4  byte enables.
- `rom_we_o`  out  1  write enable.
- `rom_data_i`  in  32  ROM read data, valid one cycle after address.

## Operation
- Per-port FSM with states IDLE, WAIT and HOLD.
  - IDLE → WAIT on grant.
  - WAIT: rvalid=1, rdata=`rom_data_i` (passthrough). rready → IDLE, or → WAIT if re-granted the same cycle. No rready → HOLD, capturing `rom_data_i` into the port buffer.
  - HOLD: rvalid=1, rdata=buffer. rready → IDLE, or → WAIT if re-granted the same cycle.
- Port eligible = req_i && (state==IDLE || (rvalid_o && rready_i)).
- Arbitration when both ports are eligible: m0 wins unless `starve_cnt`==`STARVE_MAX`, in which case m1 wins. At most one grant per cycle.
- `starve_cnt`: increments when m0 is granted while m1 is eligible. Clears when m1 is granted or m1_req_i=0. Saturates at `STARVE_MAX`.
- ROM drive while a port is granted: that port's addr, wdata, sel and we are passed through. With no grant: addr=m0_addr_i, data=0, sel=0, we=0.
- m1 write: ROM is written at the grant edge. The response the next cycle has rdata=0 and err=0, and still requires rready.
- m0 is read-only; it always drives sel=4'hF and we=0.
- A request is not held in the arbiter: a master keeps req asserted until it sees gnt.
- Reset: every output is 0 except `rom_addr_o` (follows m0_addr_i); FSMs go to IDLE; starve_cnt=0; buffers=0. A reset mid-transaction drops the pending response without emitting it.

## Timing
- Grant is combinational in cycle N; ROM samples the address at the end of N; rvalid is asserted in N+1. Read latency is 1 cycle when rready=1.
- Back-to-back on one port, with the other idle: 1 grant per cycle, full throughput.
- Response data is stable from rvalid rise until the accepting edge (HOLD buffer).
- Simultaneous rready and req on the same port: accept and re-grant in the same cycle.
- m1 is guaranteed a grant within `STARVE_MAX`+1 cycles of becoming eligible.

## Configuration
- `ROM_ARB_WP_EN` defined: ROM write protect.
  - m1 writes are granted but `rom_we_o` stays 0 and sel=0.
  - The response returns with `m1_err_o`=1 and rdata=0.
- `ROM_ARB_WP_EN` undefined: writes pass to the ROM and `m1_err_o` is tied 0.

## Test plan
- Reset, then m0 reads 0x0, 0x4, 0x8 with rready=1 → grants in 3 consecutive cycles; rdata equals the preloaded words, each 1 cycle later.
- m0 read 0x10 with rready=0 for 3 cycles → rvalid is held; rdata is stable at the word while m0_addr_i changes to 0x20; m0 is not re-granted until rready=1.
- m0 and m1 both request continuously, `STARVE_MAX`=4 → grant pattern m0,m0,m0,m0,m1 repeating.
- m1 writes 0xDEADBEEF to 0x40 with sel=4'hF, then reads 0x40 → without the macro, reads 0xDEADBEEF and err=0. With `ROM_ARB_WP_EN`, reads the original value and the write response has err=1.
- m1 writes 0x000000AA to 0x44 with sel=4'h1 → only byte 0 changes; bytes 1–3 keep their preloaded values.
- Assert rst while m0 is in HOLD → the next cycle has all rvalid=0 and gnt=0; the first request after release is served normally.
